// File: rtl/fetch_issue_unit.sv
// Fetch/issue front end: owns the PC, fetches words over a req/ack handshake,
// issues them to the controller and applies its jump/branch verdict.
module fetch_issue_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter logic [4:0]  HALT_OP  = 5'b11111
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic        pcsrc,
    output logic [4:0]  op,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALTED,
        ERROR
    } state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, instr_nxt, next_pc, branch_target, jump_target;
    logic [15:0] wait_cnt, wait_cnt_nxt;

    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:29], instr[26:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

    // Jump outranks branch when the controller asserts both.
    always_comb begin
        if (jump)       next_pc = jump_target;
        else if (pcsrc) next_pc = branch_target;
        else            next_pc = pc_plus4;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = instr;
        wait_cnt_nxt = wait_cnt;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        halted       = 1'b0;
        fetch_err    = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_nxt    = imem_rdata;
                    wait_cnt_nxt = 16'd0;
                    state_nxt    = ISSUE;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                // HALT beats stall: the halting instruction never advances the PC.
                if (instr[31:27] == HALT_OP) begin
                    state_nxt = HALTED;
                end else if (!stall) begin
                    pc_nxt    = next_pc;
                    state_nxt = FETCH;
                end
            end
            HALTED:  halted    = 1'b1;
            ERROR:   fetch_err = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    assign op        = instr_valid ? instr[31:27] : 5'd0;
    assign imem_addr = imem_req ? {pc[31:2], 2'b00} : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr    <= 32'd0;
            wait_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            instr    <= instr_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Instruction-side counterpart of the single-cycle controller. Owns the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Presents the 5-bit opcode and full instruction to the controller, then consumes the controller's jump/pcsrc verdict to pick the next PC.
- Adds wait-state tolerance, stall hold, HALT opcode detection and a fetch-timeout error.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- TIMEOUT, 16, max cycles FETCH waits for imem_ack before ERROR (2..65535).
- HALT_OP, 5'b11111, opcode that stops fetching.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  32  word address = pc; bits [1:0] always 0.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word, valid only when imem_ack=1.
- stall  in  1  hold current instruction in ISSUE.
- jump  in  1  from controller; take jump target.
- pcsrc  in  1  from controller (branch & zero); take branch target.
- op  out  5  instr[31:27]; 0 when instr_valid=0.
- instr  out  32  latched instruction word.
- instr_valid  out  1  op/instr valid for the controller this cycle.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- halted  out  1  sticky; HALT_OP issued.
- fetch_err  out  1  sticky; timeout occurred.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=0, wait_cnt=0.
  - All outputs 0 except pc and pc_plus4.
  - Reset mid-handshake abandons it; a late imem_ack after reset is ignored unless in FETCH.
- IDLE: imem_req=0. Next cycle -> FETCH unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_ack=1: instr<=imem_rdata, wait_cnt<=0, -> ISSUE. Ack in the first FETCH cycle is legal (zero wait states).
  - Else wait_cnt++. When wait_cnt==TIMEOUT-1 and no ack -> ERROR.
- ISSUE:
  - instr_valid=1; op=instr[31:27].
  - If op==HALT_OP: -> HALTED next cycle; pc unchanged; jump/pcsrc ignored.
  - stall=1: stay; pc and instr held; jump/pcsrc ignored.
  - stall=0: pc<=next_pc, -> FETCH.
- next_pc priority (jump > pcsrc > sequential):
  - jump=1: {pc_plus4[31:29], instr[26:0], 2'b00}.
  - pcsrc=1: pc_plus4 + (sign_extend(instr[15:0]) << 2), modulo 2^32.
  - Otherwise: pc_plus4.
  - jump and pcsrc both 1: jump wins.
- HALTED: halted=1, imem_req=0, instr_valid=0; terminal until reset.
- ERROR: fetch_err=1, imem_req=0, instr_valid=0; terminal until reset; pc holds the faulting address.
- imem_ack in IDLE/ISSUE/HALTED/ERROR: ignored, no state change.
- Throughput: 2 cycles per instruction with zero wait states and no stall. Each ack wait cycle adds 1; each stall cycle adds 1.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, no error.

Test Plan:
- Reset release, ack same cycle every fetch, rdata=sequential ALU ops -> imem_addr 0,4,8,12 on alternating cycles; instr_valid high every 2nd cycle; op=rdata[31:27].
- ISSUE with instr[15:0]=16'hFFFE, pcsrc=1, pc=0x20 -> next imem_addr=0x1C. With jump=1 as well -> jump target {3'b000, instr[26:0], 2'b00} taken.
- Ack delayed 3 cycles, then stall=1 for 2 cycles in ISSUE -> imem_req high 4 cycles; instr/pc stable through stall; pcsrc pulse during stall has no effect.
- Never ack, TIMEOUT=16 -> fetch_err=1 after the 16th FETCH cycle; imem_req=0 afterward; pc unchanged.
- rdata op=5'b11111 -> halted=1 the cycle after ISSUE; no further imem_req.
- rst_n low mid-FETCH while ack arrives -> pc=RESET_PC, outputs 0; fetch restarts at RESET_PC.
